// File: rtl/lbr_record_unit.sv
// Last-branch-record ring buffer: captures qualifying control transfers
// and serves indexed reads (0 = most recent) with one cycle of latency.
module lbr_record_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_BITS   = 12,
  parameter int LBR_SIZE       = 16,
  parameter int FREEZE_ON_FULL = 0,
  localparam int IW = $clog2(LBR_SIZE),
  localparam int CW = IW + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    rec_valid,
  input  logic [ADDRESS_BITS-1:0] rec_from,
  input  logic [ADDRESS_BITS-1:0] rec_to,
  input  logic [1:0]              rec_kind,
  input  logic [2:0]              kind_mask,
  input  logic                    clear,
  input  logic                    freeze,
  input  logic                    rd_req,
  input  logic [IW-1:0]           rd_index,
  input  logic                    rd_field,
  output logic                    rd_valid,
  output logic                    rd_hit,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [CW-1:0]           count,
  output logic                    overflow,
  output logic                    frozen
);

  localparam int EW = (ADDRESS_BITS > DATA_WIDTH) ? ADDRESS_BITS : DATA_WIDTH;

  logic [ADDRESS_BITS-1:0] r_from [LBR_SIZE];
  logic [ADDRESS_BITS-1:0] r_to   [LBR_SIZE];
  logic [IW-1:0]           r_wptr;
  logic [CW-1:0]           r_count;
  logic                    r_overflow;
  logic                    r_full_frz;
  logic                    r_rd_valid;
  logic                    r_rd_hit;
  logic [DATA_WIDTH-1:0]   r_rd_data;

  logic                    w_kind_en;
  logic                    w_frozen;
  logic                    w_qual;
  logic                    w_accept;
  logic                    w_drop;
  logic                    w_full;
  logic                    w_almost;
  logic                    w_hit;
  logic [IW-1:0]           w_slot;
  logic [ADDRESS_BITS-1:0] w_field;
  logic [EW-1:0]           w_ext;

  always_comb begin
    w_kind_en = 1'b0;
    unique case (rec_kind)
      2'd0:    w_kind_en = kind_mask[0];
      2'd1:    w_kind_en = kind_mask[1];
      2'd2:    w_kind_en = kind_mask[2];
      default: w_kind_en = 1'b0;
    endcase
  end

  assign w_frozen = freeze | r_full_frz;
  assign w_qual   = rec_valid & ~stall & w_kind_en;
  assign w_accept = w_qual & ~w_frozen & ~clear;
  // Only a full-freeze drop counts as loss; a software freeze is intentional.
  assign w_drop   = w_qual & r_full_frz & ~clear;
  assign w_full   = (r_count == CW'(LBR_SIZE));
  assign w_almost = (r_count == CW'(LBR_SIZE - 1));

  assign w_slot  = r_wptr - IW'(1) - rd_index;
  assign w_hit   = (CW'(rd_index) < r_count);
  assign w_field = rd_field ? r_to[w_slot] : r_from[w_slot];
  assign w_ext   = EW'(w_field);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_full_frz <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_hit   <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= rd_req;
      if (rd_req) begin
        r_rd_hit  <= w_hit;
        r_rd_data <= w_hit ? w_ext[DATA_WIDTH-1:0] : '0;
      end
      if (clear) begin
        r_wptr     <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
        r_full_frz <= 1'b0;
      end else begin
        if (w_accept) begin
          r_wptr <= r_wptr + IW'(1);
          if (!w_full)
            r_count <= r_count + CW'(1);
          if (w_full && FREEZE_ON_FULL == 0)
            r_overflow <= 1'b1;
          if (w_almost && FREEZE_ON_FULL != 0)
            r_full_frz <= 1'b1;
        end
        if (w_drop)
          r_overflow <= 1'b1;
      end
    end
  end

  // Entry storage is never reset; clear only rewinds the pointer.
  always_ff @(posedge clock) begin
    if (!reset && w_accept) begin
      r_from[r_wptr] <= rec_from;
      r_to[r_wptr]   <= rec_to;
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_hit   = r_rd_hit;
  assign rd_data  = r_rd_data;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign frozen   = w_frozen;

endmodule

// File: tb/tb_lbr_record_unit.sv
// Directed bench for lbr_record_unit: a wrapping instance and a
// freeze-on-full instance share the same stimulus.
module tb_lbr_record_unit;

  logic        clock = 1'b0;
  logic        reset, stall, rec_valid, clear, freeze, rd_req, rd_field;
  logic [11:0] rec_from, rec_to;
  logic [1:0]  rec_kind;
  logic [2:0]  kind_mask;
  logic [3:0]  rd_index;

  logic        v0, h0, o0, f0, v1, h1, o1, f1;
  logic [31:0] d0, d1;
  logic [4:0]  c0, c1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  lbr_record_unit u0 (
    .clock(clock), .reset(reset), .stall(stall), .rec_valid(rec_valid),
    .rec_from(rec_from), .rec_to(rec_to), .rec_kind(rec_kind),
    .kind_mask(kind_mask), .clear(clear), .freeze(freeze),
    .rd_req(rd_req), .rd_index(rd_index), .rd_field(rd_field),
    .rd_valid(v0), .rd_hit(h0), .rd_data(d0), .count(c0),
    .overflow(o0), .frozen(f0)
  );

  lbr_record_unit #(.FREEZE_ON_FULL(1)) u1 (
    .clock(clock), .reset(reset), .stall(stall), .rec_valid(rec_valid),
    .rec_from(rec_from), .rec_to(rec_to), .rec_kind(rec_kind),
    .kind_mask(kind_mask), .clear(clear), .freeze(freeze),
    .rd_req(rd_req), .rd_index(rd_index), .rd_field(rd_field),
    .rd_valid(v1), .rd_hit(h1), .rd_data(d1), .count(c1),
    .overflow(o1), .frozen(f1)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    reset = 0; stall = 0; rec_valid = 0; clear = 0; freeze = 0;
    rd_req = 0; rd_field = 0; rd_index = 0;
    rec_from = 0; rec_to = 0; rec_kind = 0;
  endtask

  task automatic push(input logic [11:0] f, input logic [11:0] t,
                      input logic [1:0] k, input logic st);
    rec_valid = 1; rec_from = f; rec_to = t; rec_kind = k; stall = st;
    tick();
    rec_valid = 0; stall = 0;
  endtask

  task automatic rd(input logic [3:0] idx, input logic fld);
    rd_req = 1; rd_index = idx; rd_field = fld;
    tick();
    rd_req = 0;
  endtask

  task automatic do_reset();
    idle();
    kind_mask = 3'b111;
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({c0, o0, v0, h0, f0} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_ctl: got c=%0d o=%b v=%b h=%b f=%b want 0", c0, o0, v0, h0, f0);
    end
    n_cmp++;
    if (d0 !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0", d0);
    end
  endtask

  task automatic test_basic();
    do_reset();
    push(12'h010, 12'h040, 2'd1, 1'b0);
    push(12'h020, 12'h080, 2'd1, 1'b0);
    push(12'h030, 12'h0C0, 2'd1, 1'b0);
    rd(4'd0, 1'b1);
    n_cmp++;
    if ({v0, h0} !== 2'b11 || d0 !== 32'h0C0) begin
      n_bad++;
      $display("FAIL basic_rd0: got v=%b h=%b d=%h want 1 1 0c0", v0, h0, d0);
    end
    n_cmp++;
    if (c0 !== 5'd3) begin
      n_bad++;
      $display("FAIL basic_count: got %0d want 3", c0);
    end
    rd(4'd2, 1'b0);
    n_cmp++;
    if (d0 !== 32'h010) begin
      n_bad++;
      $display("FAIL basic_rd2: got %h want 010", d0);
    end
    tick();
    n_cmp++;
    if (v0 !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_pulse: got rd_valid=%b want 0", v0);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int n = 1; n <= 15; n++)
      push(12'(n), 12'(n + 256), 2'd0, 1'b0);
    n_cmp++;
    if (f1 !== 1'b0) begin
      n_bad++;
      $display("FAIL fof_early: got frozen=%b want 0", f1);
    end
    push(12'd16, 12'd272, 2'd0, 1'b0);
    n_cmp++;
    if ({f0, f1, o1, c1} !== {3'b010, 5'd16}) begin
      n_bad++;
      $display("FAIL fof_fill: got f0=%b f1=%b o1=%b c1=%0d want 0 1 0 16", f0, f1, o1, c1);
    end
    push(12'd17, 12'd273, 2'd0, 1'b0);
    n_cmp++;
    if ({o0, c0} !== {1'b1, 5'd16}) begin
      n_bad++;
      $display("FAIL wrap_flags: got o=%b c=%0d want 1 16", o0, c0);
    end
    n_cmp++;
    if ({o1, c1} !== {1'b1, 5'd16}) begin
      n_bad++;
      $display("FAIL fof_drop: got o=%b c=%0d want 1 16", o1, c1);
    end
    rd(4'd15, 1'b0);
    n_cmp++;
    if (d0 !== 32'd2) begin
      n_bad++;
      $display("FAIL wrap_idx15: got %h want 2", d0);
    end
    rd(4'd0, 1'b0);
    n_cmp++;
    if (d0 !== 32'd17 || d1 !== 32'd16) begin
      n_bad++;
      $display("FAIL idx0: got u0=%0d u1=%0d want 17 16", d0, d1);
    end
    clear = 1;
    tick();
    clear = 0;
    n_cmp++;
    if ({f1, o1, c1, o0, c0} !== 13'd0) begin
      n_bad++;
      $display("FAIL clear: got f1=%b o1=%b c1=%0d o0=%b c0=%0d want 0", f1, o1, c1, o0, c0);
    end
  endtask

  task automatic test_kind_mask();
    do_reset();
    kind_mask = 3'b001;
    push(12'h0AA, 12'h0AB, 2'd0, 1'b1);
    push(12'h0B1, 12'h0B2, 2'd1, 1'b0);
    push(12'h0C1, 12'h0C2, 2'd2, 1'b0);
    push(12'h0D1, 12'h0D2, 2'd3, 1'b0);
    push(12'h055, 12'h056, 2'd0, 1'b0);
    kind_mask = 3'b111;
    push(12'h0E1, 12'h0E2, 2'd3, 1'b0);
    n_cmp++;
    if (c0 !== 5'd1) begin
      n_bad++;
      $display("FAIL mask_count: got %0d want 1", c0);
    end
    rd(4'd0, 1'b0);
    n_cmp++;
    if (d0 !== 32'h055) begin
      n_bad++;
      $display("FAIL mask_entry: got %h want 055", d0);
    end
    freeze = 1;
    push(12'h066, 12'h067, 2'd0, 1'b0);
    n_cmp++;
    if ({f0, c0} !== {1'b1, 5'd1}) begin
      n_bad++;
      $display("FAIL sw_freeze: got f=%b c=%0d want 1 1", f0, c0);
    end
    freeze = 0;
  endtask

  task automatic test_same_cycle();
    do_reset();
    push(12'h011, 12'h021, 2'd0, 1'b0);
    push(12'h012, 12'h022, 2'd0, 1'b0);
    rd(4'd5, 1'b0);
    n_cmp++;
    if ({v0, h0} !== 2'b10 || d0 !== 32'd0) begin
      n_bad++;
      $display("FAIL miss: got v=%b h=%b d=%h want 1 0 0", v0, h0, d0);
    end
    rec_valid = 1; rec_from = 12'h013; rec_to = 12'h023; rec_kind = 2'd0;
    rd(4'd0, 1'b0);
    rec_valid = 0;
    n_cmp++;
    if (d0 !== 32'h012 || c0 !== 5'd3) begin
      n_bad++;
      $display("FAIL rd_wr: got d=%h c=%0d want 012 3", d0, c0);
    end
    clear = 1; rec_valid = 1; rec_from = 12'h014; rec_to = 12'h024;
    rd(4'd0, 1'b1);
    clear = 0; rec_valid = 0;
    n_cmp++;
    if ({h0, c0} !== {1'b1, 5'd0} || d0 !== 32'h023) begin
      n_bad++;
      $display("FAIL clr_rd: got h=%b c=%0d d=%h want 1 0 023", h0, c0, d0);
    end
    rd(4'd0, 1'b1);
    n_cmp++;
    if (h0 !== 1'b0 || d0 !== 32'd0) begin
      n_bad++;
      $display("FAIL clr_empty: got h=%b d=%h want 0 0", h0, d0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int n = 1; n <= 17; n++)
      push(12'(n), 12'(n), 2'd2, 1'b0);
    n_cmp++;
    if (o0 !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_ovf: got %b want 1", o0);
    end
    reset = 1; rec_valid = 1; rec_from = 12'h3FF; rd_req = 1; rd_index = 0;
    tick();
    reset = 0; rec_valid = 0; rd_req = 0;
    n_cmp++;
    if ({c0, o0, v0, c1, o1, v1} !== 14'd0) begin
      n_bad++;
      $display("FAIL reset_mid: got c=%0d o=%b v=%b c1=%0d o1=%b v1=%b want 0", c0, o0, v0, c1, o1, v1);
    end
    tick();
    n_cmp++;
    if (c0 !== 5'd0) begin
      n_bad++;
      $display("FAIL reset_drop: got c=%0d want 0", c0);
    end
  endtask

  initial begin
    idle();
    kind_mask = 3'b111;
    test_reset();
    test_basic();
    test_overflow();
    test_kind_mask();
    test_same_cycle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
